// File: rtl/load_store_unit_if.sv
// Request/response handshake toward the MEM stage plus the word-wide data-memory bus.
// slave modport is the LSU view; master modport is the core/memory-side view.
interface load_store_unit_if #(
    parameter int unsigned MEM_AW = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addrs;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       write_data;
    logic [31:0]       read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addrs, mem_read, mem_write, write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addrs, mem_read, mem_write, write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V data-side load/store unit: B/H/W loads and stores, sub-word stores via read-modify-write.
// Optional one-entry last-word cache enabled by defining LSU_LAST_WORD_CACHE_EN.
module load_store_unit #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [MEM_AW+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        merged_q, merged_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               req_err;
    logic [31:0]        wr_word;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic        is_half,
                                                input logic [1:0]  off,
                                                input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] ins;
        if (is_half) begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            ins  = {16'b0, wd} << {off[1], 4'b0000};
        end else begin
            mask = 32'h0000_00FF << {off, 3'b000};
            ins  = {24'b0, wd[7:0]} << {off, 3'b000};
        end
        return (word & ~mask) | (ins & mask);
    endfunction

    // Illegal funct3, store with unsigned funct3, misalignment, or beyond the memory window.
    assign req_err = (bus.req_funct3 == 3'b011)
                  || (bus.req_funct3[2:1] == 2'b11)
                  || (bus.req_we && bus.req_funct3[2])
                  || ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                  || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                  || (|bus.req_addr[31:MEM_AW+2]);

    assign wr_word = (f3_q == 3'b010) ? wdata_q : merged_q;

`ifdef LSU_LAST_WORD_CACHE_EN
    logic              c_valid_q, c_valid_d;
    logic [MEM_AW-1:0] c_tag_q, c_tag_d;
    logic [31:0]       c_data_q, c_data_d;
    logic              c_hit;

    assign c_hit = c_valid_q && (c_tag_q == bus.req_addr[MEM_AW+1:2]);
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_LAST_WORD_CACHE_EN
        c_valid_d = c_valid_q;
        c_tag_d   = c_tag_q;
        c_data_d  = c_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr[MEM_AW+1:0];
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!bus.req_we) begin
                        state_d = S_LD;
`ifdef LSU_LAST_WORD_CACHE_EN
                        if (c_hit) begin
                            rdata_d = load_extract(c_data_q, bus.req_funct3, bus.req_addr[1:0]);
                            state_d = S_RESP;
                        end
`endif
                    end else if (bus.req_funct3 == 3'b010) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
`ifdef LSU_LAST_WORD_CACHE_EN
                        if (c_hit) begin
                            merged_d = store_merge(c_data_q, bus.req_funct3[0],
                                                   bus.req_addr[1:0], bus.req_wdata[15:0]);
                            state_d  = S_WR;
                        end
`endif
                    end
                end
            end
            S_LD: begin
                rdata_d = load_extract(bus.read_data, f3_q, addr_q[1:0]);
                state_d = S_RESP;
`ifdef LSU_LAST_WORD_CACHE_EN
                c_valid_d = 1'b1;
                c_tag_d   = addr_q[MEM_AW+1:2];
                c_data_d  = bus.read_data;
`endif
            end
            S_RMW_RD: begin
                merged_d = store_merge(bus.read_data, f3_q[0], addr_q[1:0], wdata_q[15:0]);
                state_d  = S_WR;
`ifdef LSU_LAST_WORD_CACHE_EN
                c_valid_d = 1'b1;
                c_tag_d   = addr_q[MEM_AW+1:2];
                c_data_d  = bus.read_data;
`endif
            end
            S_WR: begin
                state_d = S_RESP;
`ifdef LSU_LAST_WORD_CACHE_EN
                c_valid_d = 1'b1;
                c_tag_d   = addr_q[MEM_AW+1:2];
                c_data_d  = wr_word;
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_LAST_WORD_CACHE_EN
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_data_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_LAST_WORD_CACHE_EN
            c_valid_q <= c_valid_d;
            c_tag_q   <= c_tag_d;
            c_data_q  <= c_data_d;
`endif
        end
    end

    // Outputs decode from state only, so an async reset drops the strobes at once.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign bus.resp_err   = (state_q == S_RESP) && err_q;
    assign bus.mem_read   = (state_q == S_LD) || (state_q == S_RMW_RD);
    assign bus.mem_write  = (state_q == S_WR);
    assign bus.mem_addrs  = addr_q[MEM_AW+1:2];
    assign bus.write_data = (state_q == S_WR) ? wr_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized requests
// checked against a transaction-level memory/cache model (honours LSU_LAST_WORD_CACHE_EN).
module tb_load_store_unit;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned NWORDS = 1 << MEM_AW;

    logic clk;
    logic rst_n;

    load_store_unit_if #(.MEM_AW(MEM_AW)) bus ();

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] dmem    [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    bit          c_valid;
    int unsigned c_word;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.read_data = bus.mem_read ? dmem[bus.mem_addrs] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_write) dmem[bus.mem_addrs] <= bus.write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: legality by access size, lane arithmetic on whole words.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd,
                         output logic e_err, output logic [31:0] e_rd, output logic [31:0] e_wd,
                         output int e_lat, output int e_nrd, output int e_nwr);
        int unsigned a, size, widx, base, unit, lane;
        logic [31:0] w;
        bit hit;
        a    = addr;
        size = 1 << f3[1:0];
        widx = (a >> 2) % NWORDS;
        base = 8 * (a % 4);
        hit  = 1'b0;
`ifdef LSU_LAST_WORD_CACHE_EN
        hit = c_valid && (c_word == widx);
`endif
        e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2])
             || (a % size != 0) || (a >= 4 * NWORDS);
        e_rd = '0; e_wd = '0; e_nrd = 0; e_nwr = 0; e_lat = 1;
        if (!e_err) begin
            w = ref_mem[widx];
            if (!we) begin
                if (size == 4) begin
                    e_rd = w;
                end else begin
                    unit = 1 << (8 * size);
                    lane = (w >> base) % unit;
                    if (!f3[2] && lane >= unit / 2) lane = lane - unit;
                    e_rd = lane;
                end
                e_lat = hit ? 1 : 2;
                e_nrd = hit ? 0 : 1;
            end else begin
                if (size == 4) begin
                    w = wd;
                end else begin
                    unit = 1 << (8 * size);
                    w = w - (((w >> base) % unit) << base) + ((wd % unit) << base);
                end
                ref_mem[widx] = w;
                e_wd  = w;
                e_nwr = 1;
                e_lat = (size == 4) ? 2 : (hit ? 2 : 3);
                e_nrd = (size == 4 || hit) ? 0 : 1;
            end
            c_valid = 1'b1;
            c_word  = widx;
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic        e_err;
        logic [31:0] e_rd, e_wd;
        int          e_lat, e_nrd, e_nwr;
        int          cyc, nrd, nwr;
        bit          got;
        model(we, f3, addr, wd, e_err, e_rd, e_wd, e_lat, e_nrd, e_nwr);
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        check("resp_idle", 32'(bus.resp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 0; nrd = 0; nwr = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            check("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.mem_read || bus.mem_write)
                check("mem_addrs", 32'(bus.mem_addrs), 32'(addr[MEM_AW+1:2]));
            if (bus.mem_read) nrd++;
            if (bus.mem_write) begin
                nwr++;
                check("write_data", bus.write_data, e_wd);
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                check("latency", 32'(cyc), 32'(e_lat));
                check("resp_rdata", bus.resp_rdata, e_rd);
                check("resp_err", 32'(bus.resp_err), 32'(e_err));
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
        check("n_read", 32'(nrd), 32'(e_nrd));
        check("n_write", 32'(nwr), 32'(e_nwr));
    endtask

    initial begin
        logic [31:0] v, a;
        logic [2:0]  f3;
        logic        we;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        for (int i = 0; i < int'(NWORDS); i++) begin
            v = $urandom;
            dmem[i]    = v;
            ref_mem[i] = v;
        end
        c_valid = 1'b0;
        c_word  = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        rst_n = 1'b0;
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_addrs", 32'(bus.mem_addrs), 32'd0);
        check("rst_write_data", bus.write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h28, 32'h1234_5678);
        do_req(1'b0, 3'b010, 32'h28, 32'h0);
        check("word10", dmem[10], 32'h1234_5678);

        do_req(1'b1, 3'b010, 32'h50, 32'hDEAD_BEEF);
        do_req(1'b1, 3'b000, 32'h51, 32'h0000_00EF);
        check("word20_sb", dmem[20], 32'hDEAD_EFEF);
        do_req(1'b0, 3'b000, 32'h51, 32'h0);
        do_req(1'b0, 3'b100, 32'h51, 32'h0);
        do_req(1'b1, 3'b001, 32'h52, 32'h0000_8001);
        check("word20_sh", dmem[20], 32'h8001_EFEF);
        do_req(1'b0, 3'b001, 32'h52, 32'h0);
        do_req(1'b0, 3'b101, 32'h52, 32'h0);

        do_req(1'b0, 3'b010, 32'h29, 32'h0);
        do_req(1'b1, 3'b001, 32'h53, 32'h0);
        do_req(1'b0, 3'b000, 32'h1000, 32'h0);
        do_req(1'b0, 3'b011, 32'h28, 32'h0);
        do_req(1'b1, 3'b100, 32'h50, 32'h0);

        // Move the last-word entry off word 20 so the aborted store really sits in RMW_RD.
        do_req(1'b0, 3'b010, 32'h28, 32'h0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h50;
        bus.req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("abort_in_rmw_rd", 32'(bus.mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_read", 32'(bus.mem_read), 32'd0);
        check("abort_mem_write", 32'(bus.mem_write), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        c_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            check("abort_ready", 32'(bus.req_ready), 32'd1);
        end
        check("abort_word20", dmem[20], 32'h8001_EFEF);
        do_req(1'b0, 3'b010, 32'h50, 32'h0);
        do_req(1'b0, 3'b010, 32'h50, 32'h0);
        do_req(1'b1, 3'b000, 32'h53, 32'h0000_00A5);

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = legal_f3[$urandom_range(0, 2)];
            else f3 = legal_f3[$urandom_range(0, 4)];
            a = 32'($urandom_range(16, 23) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            do_req(we, f3, a, $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < int'(NWORDS); i++) begin
            check("final_mem", dmem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-side load/store unit between the RISC-V core's MEM stage and the word-addressed data memory block. It handles LB/LH/LW/LBU/LHU/SB/SH/SW and checks alignment and range. Because the memory has no byte enables, sub-word stores use read-modify-write. It presents a single-request handshake upstream and drives the memory's mem_addrs/mem_read/mem_write/write_data/read_data interface downstream.

Parameters:
MEM_AW, 10, word-address width of data memory (memory holds 2^MEM_AW 32-bit words)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present from MEM stage
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for B/H)
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
mem_addrs  out  MEM_AW  word address = addr[MEM_AW+1:2]
mem_read  out  1  memory read strobe; read_data is combinational while high
mem_write  out  1  memory write strobe; memory writes on the rising edge while high
write_data  out  32  word to write
read_data  in  32  word from memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_addrs=0; write_data=0. Strobes drop immediately, not at the next edge.
- Accept in IDLE: latch we, funct3, addr, wdata. Classify at accept:
  - err if funct3 ∈ {011,110,111};
  - err if a store uses funct3 bit2 = 1;
  - err if H/HU with addr[0]=1;
  - err if W with addr[1:0]≠0;
  - err if addr[31:MEM_AW+2]≠0.
- States:
  - IDLE: accept. err→RESP. Load→LD. SW→WR. SB/SH→RMW_RD.
  - LD: mem_read=1. At the edge, capture the lane of read_data selected by addr[1:0] and extend it: sign-extend for B/H, zero-extend for BU/HU, none for W. →RESP.
  - RMW_RD: mem_read=1. At the edge, register merged = read_data with the byte lane addr[1:0] (B) or half lane addr[1] (H) replaced by wdata. →WR.
  - WR: mem_write=1; write_data = wdata (SW) or merged (SB/SH). →RESP.
  - RESP: resp_valid=1 for one cycle with rdata/err. →IDLE. No new request is accepted in RESP.
- Latency (resp_valid cycle, counting the accept edge as cycle 0):
  - err: cycle 1.
  - load, SW: cycle 2.
  - SB/SH: cycle 3.
- mem_addrs is stable from the first memory cycle through WR.
- mem_read and mem_write are never high together. Neither is asserted for err requests.
- Reset mid-operation aborts the request with no response. A store in RMW_RD leaves memory unchanged.

Optional Feature:
LSU_LAST_WORD_CACHE_EN
- Defined: adds a one-entry cache (valid, word tag, data).
  - Cache update: filled on every LD/RMW_RD read and on every WR (with the written word).
  - Load hit: skips LD; rdata is extracted from the cache; resp_valid at cycle 1.
  - SB/SH hit: skips RMW_RD; merge is done from the cache; →WR.
  - Cache invalidated on reset.
  - Memory is private to the LSU, so the cache is coherent.
- Undefined: no cache; latencies as above.

Test Plan:
1. SW 0x12345678 @0x28, then LW @0x28 → WR cycle shows mem_addrs=10, mem_write=1, write_data=0x12345678; load resp_rdata=0x12345678, resp_err=0; resp_valid at cycle 2 for both.
2. SW 0xDEADBEEF @0x50; SB wdata=0xEF @0x51 → word 20 = 0xDEADEFEF, store resp at cycle 3; LB @0x51 → 0xFFFFFFEF; LBU @0x51 → 0x000000EF.
3. SH 0x8001 @0x52 → word 20 = 0x8001EFEF; LH @0x52 → 0xFFFF8001; LHU @0x52 → 0x00008001.
4. LW @0x29, SH @0x53, LB @0x1000 (MEM_AW=10), funct3=011 → each gives resp_err=1, resp_rdata=0, resp_valid at cycle 1; mem_read/mem_write stay 0 throughout.
5. SB @0x50 with rst_n pulsed low during RMW_RD → mem_read drops immediately, no resp_valid, word 20 unchanged; req_ready=1 after release; subsequent LW @0x50 returns the pre-store value.
6. With LSU_LAST_WORD_CACHE_EN: LW @0x28 twice → second has no mem_read and resp_valid at cycle 1; SB to same word → no RMW_RD cycle, resp at cycle 2.
